// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the parametrised L1 data cache.
// Address layout from LSB up: byte offset, word-in-line offset, set index, tag.
package cache_pkg;

  typedef enum logic [2:0] {IDLE, WB, FREQ, FWAIT, RESP} state_t;

  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int word_w(input int line_w, input int data_w);
    return $clog2(line_w / data_w);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int data_w, input int line_w, input int sets);
    return addr_w - off_w(data_w) - word_w(line_w, data_w) - idx_w(sets);
  endfunction

endpackage

// File: rtl/l1_dcache_param_if.sv
// Core request/response handshake and L2 request/fill port of the L1 data cache.
// The slave view is the cache itself; the master view is the core plus the L2.
interface l1_dcache_param_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 256,
  parameter int ID_W   = 3
);
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;
  logic              rw_in;
  logic              valid_in;
  logic [ID_W-1:0]   id_in;
  logic [DATA_W-1:0] data_out;
  logic [ID_W-1:0]   id_out;
  logic              ready_out;
  logic              stall_out;
  logic [ADDR_W-1:0] addr_l2_o;
  logic [LINE_W-1:0] data_l2_o;
  logic              rw_l2_o;
  logic              valid_l2_o;
  logic              stall_l2_i;
  logic [LINE_W-1:0] data_l2_i;
  logic              valid_l2_i;

  modport master (
    output addr_in, data_in, rw_in, valid_in, id_in, stall_l2_i, data_l2_i, valid_l2_i,
    input  data_out, id_out, ready_out, stall_out, addr_l2_o, data_l2_o, rw_l2_o, valid_l2_o
  );

  modport slave (
    input  addr_in, data_in, rw_in, valid_in, id_in, stall_l2_i, data_l2_i, valid_l2_i,
    output data_out, id_out, ready_out, stall_out, addr_l2_o, data_l2_o, rw_l2_o, valid_l2_o
  );
endinterface

// File: rtl/cache_line_store.sv
// Direct-mapped line storage: one combinational read port, one write port that can
// replace a whole line and/or merge a single word. Only valid/dirty bits are reset.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int DATA_W = 32,
  parameter int SETS   = 64,
  parameter int TAG_W  = 21,
  localparam int IDX_W  = idx_w(SETS),
  localparam int WORD_W = word_w(LINE_W, DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic              wr_full,
  input  logic              wr_word_en,
  input  logic              wr_dirty,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic [WORD_W-1:0] wr_word_sel,
  input  logic [DATA_W-1:0] wr_word
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];
  logic [LINE_W-1:0] merged;

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  // A fill's store word is merged on top of the incoming line in the same write.
  always_comb begin
    merged = wr_full ? wr_line : data_q[wr_index];
    if (wr_word_en)
      merged[int'(wr_word_sel) * DATA_W +: DATA_W] = wr_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      if (wr_full)
        valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_index] <= merged;
      if (wr_full)
        tag_q[wr_index] <= wr_tag;
    end
  end

endmodule

// File: rtl/l1_dcache_param.sv
// Direct-mapped write-back/write-allocate L1 data cache: FSM, miss request latch
// and registered core response. Blocks on a miss; one L2 transaction at a time.
module l1_dcache_param
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 64,
  parameter int ID_W   = 3
) (
  input logic            clk,
  input logic            reset,
  l1_dcache_param_if.slave bus
);

  localparam int OFF_W   = off_w(DATA_W);
  localparam int WORD_W  = word_w(LINE_W, DATA_W);
  localparam int IDX_W   = idx_w(SETS);
  localparam int TAG_W   = tag_w(ADDR_W, DATA_W, LINE_W, SETS);
  localparam int LOW_W   = OFF_W + WORD_W;
  localparam int TAG_LSB = LOW_W + IDX_W;

  state_t state_q, state_d;

  logic [TAG_W-1:0]  req_tag_q;
  logic [IDX_W-1:0]  req_idx_q;
  logic [WORD_W-1:0] req_word_q;
  logic [DATA_W-1:0] req_data_q;
  logic              req_rw_q;
  logic [ID_W-1:0]   req_id_q;

  logic [TAG_W-1:0]  in_tag;
  logic [IDX_W-1:0]  in_idx;
  logic [WORD_W-1:0] in_word;
  logic [IDX_W-1:0]  cur_idx;
  logic [WORD_W-1:0] cur_word;
  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              accept, hit, hit_accept, miss_accept, fill;
  logic              wr_en, wr_word_en;
  logic [DATA_W-1:0] rd_word, fill_word;

  assign in_tag  = bus.addr_in[ADDR_W-1:TAG_LSB];
  assign in_idx  = bus.addr_in[LOW_W +: IDX_W];
  assign in_word = bus.addr_in[OFF_W +: WORD_W];

  // Outside IDLE the store is addressed by the latched miss, which keeps the victim visible during WB.
  assign cur_idx  = (state_q == IDLE) ? in_idx  : req_idx_q;
  assign cur_word = (state_q == IDLE) ? in_word : req_word_q;

  assign accept      = bus.valid_in && (state_q == IDLE);
  assign hit         = rd_valid && (rd_tag == in_tag);
  assign hit_accept  = accept && hit;
  assign miss_accept = accept && !hit;
  assign fill        = (state_q == FWAIT) && bus.valid_l2_i;
  assign wr_word_en  = (hit_accept && bus.rw_in) || (fill && req_rw_q);
  assign wr_en       = wr_word_en || fill;
  assign rd_word     = rd_line[int'(cur_word) * DATA_W +: DATA_W];
  assign fill_word   = bus.data_l2_i[int'(req_word_q) * DATA_W +: DATA_W];

  cache_line_store #(
    .LINE_W(LINE_W), .DATA_W(DATA_W), .SETS(SETS), .TAG_W(TAG_W)
  ) u_store (
    .clk        (clk),
    .reset      (reset),
    .rd_index   (cur_idx),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .wr_en      (wr_en),
    .wr_full    (fill),
    .wr_word_en (wr_word_en),
    .wr_dirty   (wr_word_en),
    .wr_index   (cur_idx),
    .wr_tag     (req_tag_q),
    .wr_line    (bus.data_l2_i),
    .wr_word_sel(cur_word),
    .wr_word    ((state_q == IDLE) ? bus.data_in : req_data_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss_accept) state_d = (rd_valid && rd_dirty) ? WB : FREQ;
      WB:      if (!bus.stall_l2_i) state_d = FREQ;
      FREQ:    if (!bus.stall_l2_i) state_d = FWAIT;
      FWAIT:   if (bus.valid_l2_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.stall_out  = (state_q != IDLE);
    bus.valid_l2_o = (state_q == WB) || (state_q == FREQ);
    bus.rw_l2_o    = (state_q == WB);
    bus.addr_l2_o  = '0;
    bus.data_l2_o  = '0;
    if (state_q == WB) begin
      bus.addr_l2_o = {rd_tag, req_idx_q, {LOW_W{1'b0}}};
      bus.data_l2_o = rd_line;
    end else if (state_q == FREQ) begin
      bus.addr_l2_o = {req_tag_q, req_idx_q, {LOW_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_tag_q  <= '0;
      req_idx_q  <= '0;
      req_word_q <= '0;
      req_data_q <= '0;
      req_rw_q   <= 1'b0;
      req_id_q   <= '0;
    end else if (miss_accept) begin
      req_tag_q  <= in_tag;
      req_idx_q  <= in_idx;
      req_word_q <= in_word;
      req_data_q <= bus.data_in;
      req_rw_q   <= bus.rw_in;
      req_id_q   <= bus.id_in;
    end
  end

  // The miss response is registered on the fill edge so it is visible for the whole RESP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ready_out <= 1'b0;
      bus.data_out  <= '0;
      bus.id_out    <= '0;
    end else begin
      bus.ready_out <= 1'b0;
      if (hit_accept) begin
        bus.ready_out <= 1'b1;
        bus.data_out  <= bus.rw_in ? bus.data_in : rd_word;
        bus.id_out    <= bus.id_in;
      end else if (fill) begin
        bus.ready_out <= 1'b1;
        bus.data_out  <= req_rw_q ? req_data_q : fill_word;
        bus.id_out    <= req_id_q;
      end
    end
  end

endmodule
